// File: rtl/ds18b20_scratchpad_writer_if.sv
// Host/engine-facing signal bundle of the DS18B20 scratchpad writer.
// The slave modport is the writer itself; the master modport is the
// combined host + 1-Wire byte engine side.
interface ds18b20_scratchpad_writer_if;
  logic        F1M;
  logic        start;
  logic [2:0]  device;
  logic [63:0] rom_code;
  logic [7:0]  th;
  logic [7:0]  tl;
  logic [1:0]  resolution;
  logic        copy_en;
  logic        bus_reset_req;
  logic        bus_reset_done;
  logic        presence;
  logic [7:0]  tx_byte;
  logic        byte_valid;
  logic        EoB;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  F1M, start, device, rom_code, th, tl, resolution, copy_en,
    input  bus_reset_done, presence, EoB,
    output bus_reset_req, tx_byte, byte_valid, busy, done, error
  );

  modport master (
    output F1M, start, device, rom_code, th, tl, resolution, copy_en,
    output bus_reset_done, presence, EoB,
    input  bus_reset_req, tx_byte, byte_valid, busy, done, error
  );
endinterface

// File: rtl/ds18b20_scratchpad_writer.sv
// Byte sequencer for writing TH/TL/config into one addressed DS18B20:
// reset, Match ROM, Write Scratchpad, TH, TL, CFG, then optionally a
// second reset, Match ROM, Copy Scratchpad and an EEPROM settle wait.
// All outputs are registered and derived from the next state.
module ds18b20_scratchpad_writer #(
  parameter int NUM_OF_DEV = 4,
  parameter int COPY_WAIT  = 10000
) (
  input  logic                          clk,
  input  logic                          rst,
  ds18b20_scratchpad_writer_if.slave    bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_MATCH, S_ROM, S_WRCMD, S_TH, S_TL, S_CFG,
    S_COPYCMD, S_CWAIT, S_DONE, S_ERR
  } state_e;

  localparam logic [13:0] WAIT_LAST = 14'(COPY_WAIT - 1);

  state_e      state_q, state_d;
  logic        pass_q, pass_d;          // 0: write pass, 1: copy pass
  logic [2:0]  cnt_q, cnt_d;            // ROM byte index
  logic [13:0] wait_q, wait_d;          // copy settle counter
  logic [63:0] rom_q, rom_d;
  logic [7:0]  th_q, th_d;
  logic [7:0]  tl_q, tl_d;
  logic [1:0]  res_q, res_d;
  logic        copy_q, copy_d;
  logic        bus_reset_req_q, bus_reset_req_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        eob;

  // An end-of-byte strobe only counts while a byte is actually offered.
  assign eob = bus.EoB & byte_valid_q;

  // Next-state, latched-field and registered-output computation.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rom_d   = rom_q;
    th_d    = th_q;
    tl_d    = tl_q;
    res_d   = res_q;
    copy_d  = copy_q;

    if (bus.F1M) begin
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          rom_d  = bus.rom_code;
          th_d   = bus.th;
          tl_d   = bus.tl;
          res_d  = bus.resolution;
          copy_d = bus.copy_en;
          pass_d = 1'b0;
          cnt_d  = 3'd0;
          wait_d = 14'd0;
          state_d = (32'(bus.device) >= NUM_OF_DEV) ? S_ERR : S_RST;
        end
        S_RST: if (bus.bus_reset_done) state_d = bus.presence ? S_MATCH : S_ERR;
        S_MATCH: if (eob) begin
          cnt_d   = 3'd0;
          state_d = S_ROM;
        end
        S_ROM: if (eob) begin
          if (cnt_q == 3'd7) state_d = pass_q ? S_COPYCMD : S_WRCMD;
          else               cnt_d   = cnt_q + 3'd1;
        end
        S_WRCMD: if (eob) state_d = S_TH;
        S_TH:    if (eob) state_d = S_TL;
        S_TL:    if (eob) state_d = S_CFG;
        S_CFG: if (eob) begin
          if (copy_q) begin
            pass_d  = 1'b1;
            state_d = S_RST;
          end else begin
            state_d = S_DONE;
          end
        end
        S_COPYCMD: if (eob) begin
          wait_d  = 14'd0;
          state_d = S_CWAIT;
        end
        S_CWAIT: begin
          if (wait_q == WAIT_LAST) state_d = S_DONE;
          else                     wait_d  = wait_q + 14'd1;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    bus_reset_req_d = (state_d == S_RST);
    byte_valid_d    = state_d inside {S_MATCH, S_ROM, S_WRCMD, S_TH, S_TL,
                                      S_CFG, S_COPYCMD};
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    error_d         = (state_d == S_ERR);

    unique case (state_d)
      S_MATCH:   byte_d = 8'h55;
      S_ROM:     byte_d = rom_d[{cnt_d, 3'b000} +: 8];
      S_WRCMD:   byte_d = 8'h4E;
      S_TH:      byte_d = th_d;
      S_TL:      byte_d = tl_d;
      S_CFG:     byte_d = {1'b0, res_d, 5'b11111};
      S_COPYCMD: byte_d = 8'h48;
      default:   byte_d = 8'h00;
    endcase
  end

  // State, latched fields and outputs; everything clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pass_q          <= 1'b0;
      cnt_q           <= 3'd0;
      wait_q          <= 14'd0;
      rom_q           <= 64'd0;
      th_q            <= 8'd0;
      tl_q            <= 8'd0;
      res_q           <= 2'd0;
      copy_q          <= 1'b0;
      bus_reset_req_q <= 1'b0;
      byte_q          <= 8'h00;
      byte_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      pass_q          <= pass_d;
      cnt_q           <= cnt_d;
      wait_q          <= wait_d;
      rom_q           <= rom_d;
      th_q            <= th_d;
      tl_q            <= tl_d;
      res_q           <= res_d;
      copy_q          <= copy_d;
      bus_reset_req_q <= bus_reset_req_d;
      byte_q          <= byte_d;
      byte_valid_q    <= byte_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign bus.bus_reset_req = bus_reset_req_q;
  assign bus.tx_byte       = byte_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_ds18b20_scratchpad_writer.sv
// Directed bench for the DS18B20 scratchpad writer: a table of whole
// transactions driven through a small 1-Wire engine model, plus hand
// sequences for mid-transaction reset, idle-F1M strobes and error timing.
module tb_ds18b20_scratchpad_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ds18b20_scratchpad_writer_if sp ();

  ds18b20_scratchpad_writer #(
    .NUM_OF_DEV (4),
    .COPY_WAIT  (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  device;
    logic [63:0] rom;
    logic [7:0]  th;
    logic [7:0]  tl;
    logic [1:0]  res;
    logic        copy_en;
    logic        pres;
    logic        perturb;
    int          exp_bytes;
    int          exp_resets;
    int          exp_done;
    int          exp_err;
    int          exp_cwait;
    logic [7:0]  exp_cfg;
  } vec_t;

  vec_t vecs [6];

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int n_resets, n_done, n_err, n_cwait, n_both, n_unstable;
  bit timeout;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One F1M tick: F1M high for one clock, then one idle clock; strobes clear.
  task automatic tick();
    sp.F1M = 1'b1;
    @(posedge clk); #1;
    sp.F1M = 1'b0;
    sp.EoB = 1'b0;
    sp.bus_reset_done = 1'b0;
    sp.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load(input vec_t v);
    sp.device     = v.device;
    sp.rom_code   = v.rom;
    sp.th         = v.th;
    sp.tl         = v.tl;
    sp.resolution = v.res;
    sp.copy_en    = v.copy_en;
  endtask

  // Engine model: answers resets after 3 ticks, ends each byte after 8 ticks.
  // stop_bytes >= 0 returns as soon as that many bytes have been taken and a
  // further byte is being offered.
  task automatic run_engine(input logic pres, input int stop_bytes, input bit perturb);
    int   gap = 0;
    logic prev_req = 1'b0;
    logic [7:0] cur = 8'h00;
    got.delete();
    n_resets = 0; n_done = 0; n_err = 0; n_cwait = 0; n_both = 0; n_unstable = 0;
    timeout = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (stop_bytes >= 0 && got.size() == stop_bytes && sp.byte_valid) begin
        timeout = 1'b0;
        return;
      end
      if (sp.done) n_done++;
      if (sp.error) n_err++;
      if (sp.done && sp.error) n_both++;
      if (!sp.busy && (n_done + n_err) > 0) begin
        timeout = 1'b0;
        return;
      end
      if (sp.bus_reset_req) begin
        if (!prev_req) n_resets++;
        gap++;
        if (gap == 3) begin
          sp.bus_reset_done = 1'b1;
          sp.presence = pres;
          gap = 0;
        end
      end else if (sp.byte_valid) begin
        if (gap == 0) cur = sp.tx_byte;
        else if (sp.tx_byte !== cur) n_unstable++;
        gap++;
        if (gap == 8) begin
          sp.EoB = 1'b1;
          got.push_back(cur);
          gap = 0;
          if (perturb && got.size() == 3) begin
            sp.th = 8'hFF;
            sp.tl = 8'h00;
            sp.resolution = 2'b01;
            sp.copy_en = ~sp.copy_en;
            sp.start = 1'b1;
          end
        end
      end else if (sp.busy && !sp.done && !sp.error) begin
        n_cwait++;
      end
      prev_req = sp.bus_reset_req;
      tick();
    end
  endtask

  function automatic void build_exp(input vec_t v);
    exp_q.delete();
    if (v.device >= 3'd4 || !v.pres) return;
    exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) exp_q.push_back(v.rom[8*i +: 8]);
    exp_q.push_back(8'h4E);
    exp_q.push_back(v.th);
    exp_q.push_back(v.tl);
    exp_q.push_back(v.exp_cfg);
    if (v.copy_en) begin
      exp_q.push_back(8'h55);
      for (int i = 0; i < 8; i++) exp_q.push_back(v.rom[8*i +: 8]);
      exp_q.push_back(8'h48);
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},   sp.bus_reset_req, 1'b0);
    check({tag, "_byte"},  sp.tx_byte,       8'h00);
    check({tag, "_valid"}, sp.byte_valid,    1'b0);
    check({tag, "_busy"},  sp.busy,          1'b0);
    check({tag, "_done"},  sp.done,          1'b0);
    check({tag, "_err"},   sp.error,         1'b0);
  endtask

  logic [7:0] t1_exp [13];
  int seen_pulse;

  initial begin
    t1_exp = '{8'h55, 8'h01, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF,
               8'h28, 8'h4E, 8'h4B, 8'h46, 8'h7F};
    //           dev   rom                   th     tl     res   cp   pr   pt  bytes rst dn er cw  cfg
    vecs[0] = '{3'd1, 64'h28FF_1234_5678_9A01, 8'h4B, 8'h46, 2'b11, 1'b0, 1'b1, 1'b0, 13, 1, 1, 0, 0,  8'h7F};
    vecs[1] = '{3'd1, 64'h28FF_1234_5678_9A01, 8'h4B, 8'h46, 2'b11, 1'b1, 1'b1, 1'b0, 23, 2, 1, 0, 20, 8'h7F};
    vecs[2] = '{3'd2, 64'h28AA_0000_1111_2202, 8'h10, 8'h05, 2'b01, 1'b0, 1'b0, 1'b0, 0,  1, 0, 1, 0,  8'h3F};
    vecs[3] = '{3'd5, 64'h2800_0000_0000_0005, 8'h20, 8'h10, 2'b11, 1'b0, 1'b1, 1'b0, 0,  0, 0, 1, 0,  8'h7F};
    vecs[4] = '{3'd0, 64'h28C3_5A5A_0F0F_F000, 8'h32, 8'hF6, 2'b00, 1'b0, 1'b1, 1'b0, 13, 1, 1, 0, 0,  8'h1F};
    vecs[5] = '{3'd3, 64'h1122_3344_5566_7788, 8'h19, 8'h0A, 2'b10, 1'b0, 1'b1, 1'b1, 13, 1, 1, 0, 0,  8'h5F};

    sp.F1M = 1'b0; sp.start = 1'b0; sp.device = 3'd0; sp.rom_code = 64'd0;
    sp.th = 8'd0; sp.tl = 8'd0; sp.resolution = 2'd0; sp.copy_en = 1'b0;
    sp.bus_reset_done = 1'b0; sp.presence = 1'b0; sp.EoB = 1'b0;

    // Reset state.
    #23;
    check_idle_outputs("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("after_reset");

    // Out-of-range device: error on the tick after start, no bus reset.
    load(vecs[3]);
    sp.start = 1'b1;
    tick();
    check("baddev_err_pulse", sp.error, 1'b1);
    check("baddev_no_req", sp.bus_reset_req, 1'b0);
    tick();
    check("baddev_err_cleared", sp.error, 1'b0);
    check("baddev_idle", sp.busy, 1'b0);

    // Table of whole transactions.
    for (int k = 0; k < 6; k++) begin
      load(vecs[k]);
      build_exp(vecs[k]);
      sp.start = 1'b1;
      tick();
      run_engine(vecs[k].pres, -1, vecs[k].perturb);
      check($sformatf("v%0d_timeout", k), timeout, 1'b0);
      check($sformatf("v%0d_nbytes", k), got.size(), vecs[k].exp_bytes);
      check($sformatf("v%0d_resets", k), n_resets, vecs[k].exp_resets);
      check($sformatf("v%0d_done", k), n_done, vecs[k].exp_done);
      check($sformatf("v%0d_error", k), n_err, vecs[k].exp_err);
      check($sformatf("v%0d_cwait", k), n_cwait, vecs[k].exp_cwait);
      check($sformatf("v%0d_both", k), n_both, 0);
      check($sformatf("v%0d_unstable", k), n_unstable, 0);
      check($sformatf("v%0d_busy_end", k), sp.busy, 1'b0);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        check($sformatf("v%0d_byte%0d", k, i), got[i], exp_q[i]);
      if (k == 0)
        for (int i = 0; i < 13 && i < got.size(); i++)
          check($sformatf("t1_byte%0d", i), got[i], t1_exp[i]);
    end

    // EoB while F1M is low must not advance the byte.
    load(vecs[0]);
    sp.start = 1'b1;
    tick();
    run_engine(1'b1, 0, 1'b0);
    check("f1m_low_reach_timeout", timeout, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sp.EoB = 1'b1;
    end
    @(negedge clk);
    sp.EoB = 1'b0;
    check("f1m_low_valid", sp.byte_valid, 1'b1);
    check("f1m_low_byte", sp.tx_byte, 8'h55);
    tick();
    tick();
    check("f1m_hold_byte", sp.tx_byte, 8'h55);

    // Asynchronous reset while ROM byte index 4 is offered.
    run_engine(1'b1, 5, 1'b0);
    check("rom4_reach_timeout", timeout, 1'b0);
    check("rom4_byte", sp.tx_byte, 8'h34);
    #3 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen_pulse = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sp.done || sp.error || sp.busy) seen_pulse++;
    end
    check("post_rst_quiet", seen_pulse, 0);
    check_idle_outputs("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
